// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: loads bitstream words LSB-first into a CLB tile column's
// configuration flip-flop chain. A CRC-16-CCITT is computed over the bits
// leaving ccff_tail, which carry the previously loaded configuration, so the
// host can check that configuration.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              config_enable,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       readback_crc
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        SHIFT,
        FINISH
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [IDX_W-1:0]  word_idx_reg;
    logic [WORD_W-1:0] sreg_reg;

    logic [15:0]       crc_next;
    logic              crc_fb;
    logic [CNT_W-1:0]  bit_cnt_next;
    logic [IDX_W-1:0]  word_idx_next;
    logic              last_bit;
    logic              last_in_word;

    // MSB-first CRC step driven by the bit currently presented on ccff_tail
    assign crc_fb      = readback_crc[15] ^ ccff_tail;
    assign crc_next[0] = CRC_POLY[0] & crc_fb;

    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_crc
            assign crc_next[gi] = readback_crc[gi-1] ^ (CRC_POLY[gi] & crc_fb);
        end
    endgenerate

    assign bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
    assign word_idx_next = word_idx_reg + IDX_W'(1);
    assign last_bit      = (bit_cnt_next == CNT_W'(CHAIN_LEN));
    assign last_in_word  = (word_idx_reg == IDX_W'(WORD_W - 1));

    // Sequencer: every output is a register updated here, so each output
    // reflects the state the FSM has just entered
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            word_idx_reg  <= '0;
            sreg_reg      <= '0;
            bs_ready      <= 1'b0;
            config_enable <= 1'b0;
            ccff_head     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            readback_crc  <= CRC_INIT;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= WAIT_WORD;
                        bit_cnt_reg  <= '0;
                        readback_crc <= CRC_INIT;
                        bs_ready     <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        bs_ready  <= 1'b0;
                        busy      <= 1'b0;
                        aborted   <= 1'b1;
                    end else if (bs_valid && bs_ready) begin
                        state_reg     <= SHIFT;
                        sreg_reg      <= bs_data;
                        word_idx_reg  <= '0;
                        ccff_head     <= bs_data[0];
                        config_enable <= 1'b1;
                        bs_ready      <= 1'b0;
                    end
                end
                SHIFT: begin
                    // config_enable is high for the whole of SHIFT, so the
                    // chain moves on every edge here and the tail bit is folded in
                    readback_crc <= crc_next;
                    bit_cnt_reg  <= bit_cnt_next;
                    if (abort) begin
                        state_reg     <= IDLE;
                        config_enable <= 1'b0;
                        busy          <= 1'b0;
                        aborted       <= 1'b1;
                    end else if (last_bit) begin
                        // chain full: any unused bits of this word are dropped
                        state_reg     <= FINISH;
                        config_enable <= 1'b0;
                        done          <= 1'b1;
                    end else if (last_in_word) begin
                        state_reg     <= WAIT_WORD;
                        config_enable <= 1'b0;
                        bs_ready      <= 1'b1;
                    end else begin
                        word_idx_reg <= word_idx_next;
                        ccff_head    <= sreg_reg[word_idx_next];
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (64-bit and 40-bit chains), each
// with its own behavioural shift-chain model; loads are checked against the
// expected chain image and a reference CRC of the preloaded contents.
module tb_ccff_chain_loader;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        start;
    logic        abort;
    logic        bs_valid;
    logic [31:0] bs_data;
    logic        sel;          // 0: 64-bit chain instance, 1: 40-bit chain instance

    logic        start_a, abort_a, valid_a, start_b, abort_b, valid_b;
    logic        rdy_a, en_a, head_a, tail_a, busy_a, done_a, ab_a;
    logic        rdy_b, en_b, head_b, tail_b, busy_b, done_b, ab_b;
    logic [15:0] crc_a, crc_b;

    logic        rdy, en, head, busy, done, ab;
    logic [15:0] crc;

    logic [63:0] chain_a;
    logic [39:0] chain_b;
    logic        pre_en;
    logic [63:0] pre_val;

    int n_checks = 0;
    int n_errors = 0;

    always #5 prog_clk = ~prog_clk;

    assign start_a = start & ~sel;
    assign abort_a = abort & ~sel;
    assign valid_a = bs_valid & ~sel;
    assign start_b = start & sel;
    assign abort_b = abort & sel;
    assign valid_b = bs_valid & sel;

    assign rdy  = sel ? rdy_b  : rdy_a;
    assign en   = sel ? en_b   : en_a;
    assign head = sel ? head_b : head_a;
    assign busy = sel ? busy_b : busy_a;
    assign done = sel ? done_b : done_a;
    assign ab   = sel ? ab_b   : ab_a;
    assign crc  = sel ? crc_b  : crc_a;

    ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(32)) dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .abort(abort_a),
        .bs_data(bs_data), .bs_valid(valid_a), .bs_ready(rdy_a),
        .config_enable(en_a), .ccff_head(head_a), .ccff_tail(tail_a),
        .busy(busy_a), .done(done_a), .aborted(ab_a), .readback_crc(crc_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .abort(abort_b),
        .bs_data(bs_data), .bs_valid(valid_b), .bs_ready(rdy_b),
        .config_enable(en_b), .ccff_head(head_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b), .aborted(ab_b), .readback_crc(crc_b)
    );

    // Chain models: head enters bit 0, tail is the top bit
    assign tail_a = chain_a[63];
    assign tail_b = chain_b[39];

    always @(posedge prog_clk) begin
        if (pre_en && !sel) chain_a <= pre_val;
        else if (en_a)      chain_a <= {chain_a[62:0], head_a};
    end

    always @(posedge prog_clk) begin
        if (pre_en && sel) chain_b <= pre_val[39:0];
        else if (en_b)     chain_b <= {chain_b[38:0], head_b};
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC over the first n bits leaving the tail of a chain holding pat
    function automatic logic [15:0] golden_crc(input logic [63:0] pat, input int len, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ pat[len-1-i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic preload(input logic [63:0] v);
        pre_val = v;
        pre_en  = 1'b1;
        @(posedge prog_clk); #1;
        pre_en  = 1'b0;
    endtask

    // One load on the selected instance. abort_at>0 aborts after that many
    // shifts; glitch_at>0 pulses start while busy after that many shifts.
    task automatic run_load(input string name, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [63:0] pat, input int stall, input int abort_at,
                            input int glitch_at);
        int          len, accepted, widx, en_cycles, runs, overlap, ndone, nab, pulse_en;
        int          wait_cnt, exp_en, cyc;
        logic        hs_pending, prev_en, finished;
        logic [31:0] words [2];
        logic [63:0] exp_chain, got_chain;

        len = sel ? 40 : 64;
        words[0] = w0;
        words[1] = w1;
        accepted = 0; widx = 0; en_cycles = 0; runs = 0; overlap = 0;
        ndone = 0; nab = 0; pulse_en = 0; wait_cnt = 0;
        hs_pending = 1'b0; prev_en = 1'b0; finished = 1'b0;

        preload(pat);
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check_eq({name, "_start_ready"}, {63'd0, rdy}, 64'd1);

        cyc = 0;
        while (!finished && cyc < 400) begin
            cyc++;
            abort = 1'b0;
            start = 1'b0;
            if (hs_pending) begin
                accepted++;
                widx++;
                bs_valid   = 1'b0;
                hs_pending = 1'b0;
                if (accepted == 1) check_eq({name, "_accept_to_en"}, {63'd0, en}, 64'd1);
            end
            if (en) en_cycles++;
            if (en && !prev_en) runs++;
            prev_en = en;
            if (en && rdy) overlap++;
            if (done) begin ndone++; if (en) pulse_en++; end
            if (ab)   begin nab++;   if (en) pulse_en++; end
            if (!busy) begin
                finished = 1'b1;
            end else begin
                if (abort_at > 0 && en && en_cycles == abort_at) abort = 1'b1;
                if (glitch_at > 0 && en && en_cycles == glitch_at) start = 1'b1;
                if (rdy && !bs_valid && !abort && widx < 2) begin
                    if (widx > 0 && wait_cnt < stall) begin
                        wait_cnt++;
                    end else begin
                        bs_valid   = 1'b1;
                        bs_data    = words[widx];
                        hs_pending = 1'b1;
                        wait_cnt   = 0;
                    end
                end
                @(posedge prog_clk); #1;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        bs_valid = 1'b0;

        check_eq({name, "_completes"}, {63'd0, finished}, 64'd1);
        exp_en = (abort_at > 0) ? abort_at : len;
        check_eq({name, "_enable_cycles"}, 64'(en_cycles), 64'(exp_en));
        check_eq({name, "_enable_runs"}, 64'(runs), 64'(accepted));
        check_eq({name, "_ready_enable_overlap"}, 64'(overlap), 64'd0);
        check_eq({name, "_enable_in_pulse"}, 64'(pulse_en), 64'd0);
        check_eq({name, "_done_pulses"}, 64'(ndone), (abort_at > 0) ? 64'd0 : 64'd1);
        check_eq({name, "_aborted_pulses"}, 64'(nab), (abort_at > 0) ? 64'd1 : 64'd0);
        check_eq({name, "_crc"}, {48'd0, crc}, {48'd0, golden_crc(pat, len, exp_en)});
        if (abort_at == 0) begin
            check_eq({name, "_words_accepted"}, 64'(accepted), 64'((len + 31) / 32));
            exp_chain = '0;
            for (int k = 0; k < len; k++) exp_chain[len-1-k] = words[k/32][k%32];
            got_chain = sel ? {24'd0, chain_b} : chain_a;
            check_eq({name, "_chain"}, got_chain, exp_chain);
        end
        $display("load %s: len=%0d words=%0d shifts=%0d done=%0d aborted=%0d crc=%04h",
                 name, len, accepted, en_cycles, ndone, nab, crc);
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq({name, "_ready"}, {63'd0, rdy_a}, 64'd0);
        check_eq({name, "_enable"}, {63'd0, en_a}, 64'd0);
        check_eq({name, "_head"}, {63'd0, head_a}, 64'd0);
        check_eq({name, "_busy"}, {63'd0, busy_a}, 64'd0);
        check_eq({name, "_done"}, {63'd0, done_a}, 64'd0);
        check_eq({name, "_aborted"}, {63'd0, ab_a}, 64'd0);
        check_eq({name, "_crc"}, {48'd0, crc_a}, 64'h0000_0000_0000_FFFF);
    endtask

    initial begin
        int shifts, g_at, a_at, cyc;
        logic [31:0] s1_w0, s1_w1;
        pReset = 1'b1; start = 1'b0; abort = 1'b0; bs_valid = 1'b0; bs_data = '0;
        sel = 1'b0; pre_en = 1'b0; pre_val = '0;
        s1_w0 = 32'hA5A5A5A5;
        s1_w1 = 32'h0F0F0F0F;

        @(posedge prog_clk); #1;
        check_reset_outputs("rst");
        @(posedge prog_clk); #1;
        pReset = 1'b0;
        @(posedge prog_clk); #1;
        check_eq("rst_release_busy_b", {63'd0, busy_b}, 64'd0);

        // Two full words into the 64-bit chain
        sel = 1'b0;
        run_load("s1", s1_w0, s1_w1, {$urandom, $urandom}, 0, 0, 0);
        // 40-bit chain: second word truncated after 8 bits
        sel = 1'b1;
        run_load("s2", $urandom, $urandom, {$urandom, $urandom}, 0, 0, 0);
        // Readback CRC of all-ones and all-zeros previous configurations
        sel = 1'b0;
        run_load("s3_ones", $urandom, $urandom, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        run_load("s3_zeros", $urandom, $urandom, 64'd0, 0, 0, 0);
        // Host stalls 5 cycles between words
        run_load("s4_stall", s1_w0, s1_w1, {$urandom, $urandom}, 5, 0, 0);
        // Abort after 10 shifts, then a clean load
        run_load("s5_abort", $urandom, $urandom, {$urandom, $urandom}, 0, 10, 0);
        run_load("s5_clean", $urandom, $urandom, {$urandom, $urandom}, 0, 0, 0);

        // Asynchronous reset in the middle of shifting
        sel = 1'b0;
        preload({$urandom, $urandom});
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        shifts = 0;
        cyc = 0;
        while (shifts < 5 && cyc < 100) begin
            cyc++;
            if (rdy_a) bs_valid = 1'b1;
            @(posedge prog_clk); #1;
            bs_valid = 1'b0;
            if (en_a) shifts++;
        end
        check_eq("s6_reached_shift", 64'(shifts), 64'd5);
        #3;
        pReset = 1'b1;
        #1;
        check_reset_outputs("s6_async_rst");
        @(posedge prog_clk); #1;
        pReset = 1'b0;
        @(posedge prog_clk); #1;
        check_eq("s6_after_rst_busy", {63'd0, busy_a}, 64'd0);

        // start pulsed while busy must be ignored
        sel = 1'b1;
        run_load("s6_glitch", $urandom, $urandom, {$urandom, $urandom}, 0, 0, 20);

        // Randomized loads
        for (int r = 0; r < 10; r++) begin
            sel  = 1'($urandom % 2);
            g_at = ($urandom % 3 == 0) ? 1 + int'($urandom % 30) : 0;
            a_at = ($urandom % 4 == 0) ? 1 + int'($urandom % 30) : 0;
            run_load($sformatf("rnd%0d", r), $urandom, $urandom, {$urandom, $urandom},
                     int'($urandom % 5), a_at, g_at);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
